// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, T-state indices, sequencer states and the strobe word.
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int T_W      = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // Bit positions of each phase in the one-hot ring counter.
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef enum logic {
        ST_RING = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic pc_inc;
        logic pc_enable;
        logic mar_load;
        logic ram_enable;
        logic ir_load;
        logic ir_enable;
        logic acc_load;
        logic acc_enable;
        logic b_load;
        logic alu_sub;
        logic alu_enable;
        logic out_load;
    } ctrl_word_t;

    function automatic logic is_undefined(input logic [OPCODE_W-1:0] op);
        return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter; advances one phase per edge while advance=1, clears to T1 on reset.
module sap1_ring_counter #(
    parameter int T_W = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           advance,
    output logic [T_W-1:0] t_state
);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_state <= T_W'(1);
        end else if (advance) begin
            t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
        end
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter plus opcode decode of all bus strobes and a HALT state.
// Optional build macro SAP1_CTRL_ILLEGAL_TRAP_EN traps undefined opcodes into HALT and sets illegal.
module sap1_controller #(
    parameter int OPCODE_W = sap1_pkg::OPCODE_W,
    parameter int T_W      = sap1_pkg::T_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic                pc_inc,
    output logic                pc_enable,
    output logic                mar_load,
    output logic                ram_enable,
    output logic                ir_load,
    output logic                ir_enable,
    output logic                acc_load,
    output logic                acc_enable,
    output logic                b_load,
    output logic                alu_sub,
    output logic                alu_enable,
    output logic                out_load,
    output logic [T_W-1:0]      t_state,
    output logic                halted,
    output logic                illegal
);

    import sap1_pkg::*;

    seq_state_t     state, state_next;
    logic [T_W-1:0] ring;
    logic           at_t4_live;
    logic           trap_hit;
    logic           go_halt;
    logic           advance;
    ctrl_word_t     ctrl;

    assign at_t4_live = (state == ST_RING) && run && ring[T4];

`ifdef SAP1_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    assign trap_hit = at_t4_live && is_undefined(ir_opcode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (trap_hit) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign trap_hit = 1'b0;
    assign illegal  = 1'b0;
`endif

    assign go_halt = at_t4_live && ((ir_opcode == OP_HLT) || trap_hit);
    assign advance = (state == ST_RING) && run && !go_halt;

    sap1_ring_counter #(.T_W(T_W)) u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance),
        .t_state (ring)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RING;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (go_halt) begin
            state_next = ST_HALT;
        end
    end

    // Strobes are gated by reset_n so they drop the instant reset asserts, not at the next edge.
    always_comb begin
        ctrl = '0;
        if (reset_n && run && (state == ST_RING)) begin
            if (ring[T1]) begin
                ctrl.pc_enable = 1'b1;
                ctrl.mar_load  = 1'b1;
            end
            if (ring[T2]) begin
                ctrl.pc_inc = 1'b1;
            end
            if (ring[T3]) begin
                ctrl.ram_enable = 1'b1;
                ctrl.ir_load    = 1'b1;
            end
            if (ring[T4]) begin
                if (ir_opcode inside {OP_LDA, OP_ADD, OP_SUB}) begin
                    ctrl.ir_enable = 1'b1;
                    ctrl.mar_load  = 1'b1;
                end else if (ir_opcode == OP_OUT) begin
                    ctrl.acc_enable = 1'b1;
                    ctrl.out_load   = 1'b1;
                end
            end
            if (ring[T5]) begin
                if (ir_opcode == OP_LDA) begin
                    ctrl.ram_enable = 1'b1;
                    ctrl.acc_load   = 1'b1;
                end else if (ir_opcode inside {OP_ADD, OP_SUB}) begin
                    ctrl.ram_enable = 1'b1;
                    ctrl.b_load     = 1'b1;
                end
            end
            if (ring[T6] && (ir_opcode inside {OP_ADD, OP_SUB})) begin
                ctrl.alu_enable = 1'b1;
                ctrl.acc_load   = 1'b1;
                ctrl.alu_sub    = (ir_opcode == OP_SUB);
            end
        end
    end

    assign pc_inc     = ctrl.pc_inc;
    assign pc_enable  = ctrl.pc_enable;
    assign mar_load   = ctrl.mar_load;
    assign ram_enable = ctrl.ram_enable;
    assign ir_load    = ctrl.ir_load;
    assign ir_enable  = ctrl.ir_enable;
    assign acc_load   = ctrl.acc_load;
    assign acc_enable = ctrl.acc_enable;
    assign b_load     = ctrl.b_load;
    assign alu_sub    = ctrl.alu_sub;
    assign alu_enable = ctrl.alu_enable;
    assign out_load   = ctrl.out_load;

    assign halted  = (state == ST_HALT);
    assign t_state = halted ? '0 : ring;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller; expectations follow the macro SAP1_CTRL_ILLEGAL_TRAP_EN when set.
module tb_sap1_controller;

    localparam logic [11:0] S_PC_INC  = 12'h800;
    localparam logic [11:0] S_PC_EN   = 12'h400;
    localparam logic [11:0] S_MAR     = 12'h200;
    localparam logic [11:0] S_RAM     = 12'h100;
    localparam logic [11:0] S_IR_LD   = 12'h080;
    localparam logic [11:0] S_IR_EN   = 12'h040;
    localparam logic [11:0] S_ACC_LD  = 12'h020;
    localparam logic [11:0] S_ACC_EN  = 12'h010;
    localparam logic [11:0] S_B_LD    = 12'h008;
    localparam logic [11:0] S_SUB     = 12'h004;
    localparam logic [11:0] S_ALU_EN  = 12'h002;
    localparam logic [11:0] S_OUT     = 12'h001;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic       pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
    logic       acc_load, acc_enable, b_load, alu_sub, alu_enable, out_load;
    logic [5:0] t_state;
    logic       halted, illegal;
    logic [11:0] strobes;

    int checks = 0;
    int errors = 0;

    sap1_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .pc_inc     (pc_inc),
        .pc_enable  (pc_enable),
        .mar_load   (mar_load),
        .ram_enable (ram_enable),
        .ir_load    (ir_load),
        .ir_enable  (ir_enable),
        .acc_load   (acc_load),
        .acc_enable (acc_enable),
        .b_load     (b_load),
        .alu_sub    (alu_sub),
        .alu_enable (alu_enable),
        .out_load   (out_load),
        .t_state    (t_state),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign strobes = {pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                      acc_load, acc_enable, b_load, alu_sub, alu_enable, out_load};

    // Bus contention guard: at most one driver on the shared bus, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        if ($countones({pc_enable, ram_enable, ir_enable, acc_enable, alu_enable}) > 1) begin
            errors++;
            $display("FAIL bus_onehot t=%0t drivers=%b required at most one",
                     $time, {pc_enable, ram_enable, ir_enable, acc_enable, alu_enable});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks T1..T3 from the current T1, checking the fetch strobes; ends in T4.
    task automatic step_fetch(input string name);
        logic [11:0] exp_s;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0:       exp_s = S_PC_EN | S_MAR;
                1:       exp_s = S_PC_INC;
                default: exp_s = S_RAM | S_IR_LD;
            endcase
            checks++;
            if (t_state !== (6'b000001 << p)) begin
                errors++;
                $display("FAIL %s_fetch_t%0d_state got=%b want=%b", name, p + 1, t_state, 6'b000001 << p);
            end
            checks++;
            if (strobes !== exp_s) begin
                errors++;
                $display("FAIL %s_fetch_t%0d_strobes got=%h want=%h", name, p + 1, strobes, exp_s);
            end
            tick();
        end
    endtask

    // Walks T4..T6 checking the execute strobes; ends in T1 of the next instruction.
    task automatic step_exec(input string name, input logic [11:0] e4, input logic [11:0] e5,
                             input logic [11:0] e6);
        logic [11:0] exp_s;
        for (int p = 3; p < 6; p++) begin
            exp_s = (p == 3) ? e4 : (p == 4) ? e5 : e6;
            checks++;
            if (t_state !== (6'b000001 << p)) begin
                errors++;
                $display("FAIL %s_exec_t%0d_state got=%b want=%b", name, p + 1, t_state, 6'b000001 << p);
            end
            checks++;
            if (strobes !== exp_s) begin
                errors++;
                $display("FAIL %s_exec_t%0d_strobes got=%h want=%h", name, p + 1, strobes, exp_s);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run = 1'b1;
        ir_opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL reset_t_state got=%b want=000001", t_state);
        end
        checks++;
        if (strobes !== 12'h000) begin
            errors++;
            $display("FAIL reset_strobes got=%h want=000", strobes);
        end
        checks++;
        if ({halted, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00", {halted, illegal});
        end
        reset_n = 1'b1;
        #1;
        step_fetch("lda");
        step_exec("lda", S_IR_EN | S_MAR, S_RAM | S_ACC_LD, 12'h000);
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL ring_wrap got=%b want=000001", t_state);
        end
    endtask

    task automatic test_arith();
        ir_opcode = 4'h1;
        step_fetch("add");
        step_exec("add", S_IR_EN | S_MAR, S_RAM | S_B_LD, S_ALU_EN | S_ACC_LD);
        ir_opcode = 4'h2;
        step_fetch("sub");
        step_exec("sub", S_IR_EN | S_MAR, S_RAM | S_B_LD, S_ALU_EN | S_ACC_LD | S_SUB);
    endtask

    task automatic test_run_hold();
        ir_opcode = 4'h0;
        tick();
        tick();
        run = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (t_state !== 6'b000100 || ir_load !== 1'b0 || strobes !== 12'h000) begin
                errors++;
                $display("FAIL run_hold_%0d t_state=%b ir_load=%b strobes=%h want 000100/0/000",
                         i, t_state, ir_load, strobes);
            end
            tick();
        end
        run = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b000100 || strobes !== (S_RAM | S_IR_LD)) begin
            errors++;
            $display("FAIL run_resume t_state=%b strobes=%h want 000100/%h", t_state, strobes, S_RAM | S_IR_LD);
        end
        tick();
        step_exec("lda_resume", S_IR_EN | S_MAR, S_RAM | S_ACC_LD, 12'h000);
    endtask

    task automatic test_reset_mid();
        ir_opcode = 4'h1;
        step_fetch("add_mid");
        tick();
        checks++;
        if (strobes !== (S_RAM | S_B_LD)) begin
            errors++;
            $display("FAIL mid_t5_strobes got=%h want=%h", strobes, S_RAM | S_B_LD);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (b_load !== 1'b0 || strobes !== 12'h000 || t_state !== 6'b000001) begin
            errors++;
            $display("FAIL mid_reset b_load=%b strobes=%h t_state=%b want 0/000/000001", b_load, strobes, t_state);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b000001 || strobes !== (S_PC_EN | S_MAR)) begin
            errors++;
            $display("FAIL mid_release t_state=%b strobes=%h want 000001/%h", t_state, strobes, S_PC_EN | S_MAR);
        end
    endtask

    task automatic test_out_hlt();
        ir_opcode = 4'hE;
        step_fetch("out");
        step_exec("out", S_ACC_EN | S_OUT, 12'h000, 12'h000);
        ir_opcode = 4'hF;
        step_fetch("hlt");
        checks++;
        if (t_state !== 6'b001000 || strobes !== 12'h000 || halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_t4 t_state=%b strobes=%h halted=%b want 001000/000/0", t_state, strobes, halted);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (halted !== 1'b1 || t_state !== 6'b000000 || strobes !== 12'h000) begin
                errors++;
                $display("FAIL halt_hold_%0d halted=%b t_state=%b strobes=%h want 1/000000/000",
                         i, halted, t_state, strobes);
            end
            run = i[0];
            tick();
        end
        run = 1'b1;
    endtask

    task automatic test_reset_from_halt();
        reset_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || t_state !== 6'b000001 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset halted=%b t_state=%b illegal=%b want 0/000001/0", halted, t_state, illegal);
        end
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_undefined();
        ir_opcode = 4'h7;
        step_fetch("undef");
`ifdef SAP1_CTRL_ILLEGAL_TRAP_EN
        checks++;
        if (t_state !== 6'b001000 || strobes !== 12'h000) begin
            errors++;
            $display("FAIL trap_t4 t_state=%b strobes=%h want 001000/000", t_state, strobes);
        end
        tick();
        checks++;
        if (illegal !== 1'b1 || halted !== 1'b1 || t_state !== 6'b000000) begin
            errors++;
            $display("FAIL trap_after illegal=%b halted=%b t_state=%b want 1/1/000000", illegal, halted, t_state);
        end
        test_reset_from_halt();
`else
        step_exec("undef", 12'h000, 12'h000, 12'h000);
        checks++;
        if (t_state !== 6'b000001 || illegal !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL nop_end t_state=%b illegal=%b halted=%b want 000001/0/0", t_state, illegal, halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_arith();
        test_run_hold();
        test_reset_mid();
        test_out_hlt();
        test_reset_from_halt();
        test_undefined();
        ir_opcode = 4'h1;
        step_fetch("post");
        step_exec("post", S_IR_EN | S_MAR, S_RAM | S_B_LD, S_ALU_EN | S_ACC_LD);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
